// File: rtl/ctrl_sequencer_if.sv
// Program memory read port between the control sequencer (master) and its
// instruction store (slave); one-cycle read latency.
interface ctrl_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 72
);
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic                  prog_en;
  logic [DATA_WIDTH-1:0] prog_dout;

  modport master (
    output prog_addr,
    output prog_en,
    input  prog_dout
  );

  modport slave (
    input  prog_addr,
    input  prog_en,
    output prog_dout
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Microprogram sequencer: fetches instructions from program memory and drives
// a registered control word to the LU datapath (EMIT / HOLD / END opcodes).
module ctrl_sequencer #(
  parameter int unsigned CTRL_WIDTH      = 60,
  parameter int unsigned PROG_ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH       = 10
) (
  input  logic                       CLK_100,
  input  logic                       RST,
  input  logic                       start,
  input  logic [PROG_ADDR_WIDTH-1:0] start_addr,
  input  logic                       stop,
  ctrl_sequencer_if.master           prog,
  output logic [CTRL_WIDTH-1:0]      CTRL_Signal,
  output logic                       ctrl_valid,
  output logic                       bram_ZYNQ_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [31:0]                run_cycles
);

  localparam int unsigned IW = CTRL_WIDTH + 2 + CNT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_EMIT = 2'b00,
    OP_HOLD = 2'b01,
    OP_END  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  state_t                     state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]       hold_q, hold_d;
  logic [CTRL_WIDTH-1:0]      ctrl_q, ctrl_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [31:0]                runc_q, runc_d;
  logic                       busy_q, busy_d;
  logic                       sel_q, sel_d;
  logic                       en_q, en_d;

  // Instruction field split of the word returned by program memory
  op_t                   instr_op;
  logic [CNT_WIDTH-1:0]  instr_cnt;
  logic [CTRL_WIDTH-1:0] instr_ctrl;

  assign instr_op   = op_t'(prog.prog_dout[IW-1 -: 2]);
  assign instr_cnt  = prog.prog_dout[IW-3 -: CNT_WIDTH];
  assign instr_ctrl = prog.prog_dout[CTRL_WIDTH-1:0];

  // State register and all registered outputs
  always_ff @(posedge CLK_100) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      hold_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      runc_q  <= '0;
      busy_q  <= 1'b0;
      sel_q   <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
      runc_q  <= runc_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    error_d = error_q;
    runc_d  = (valid_q && (runc_q != 32'hFFFF_FFFF)) ? runc_q + 32'd1 : runc_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    sel_d   = 1'b1;
    en_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          pc_d    = start_addr;
          error_d = 1'b0;
          runc_d  = '0;
        end
      end

      S_FETCH: begin
        if (stop) begin
          state_d = S_IDLE;
          ctrl_d  = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else begin
          state_d = S_RUN;
          pc_d    = pc_q + PROG_ADDR_WIDTH'(1);
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          ctrl_d  = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else if (hold_q != '0) begin
          // Holding: word stays, the prefetched instruction is kept at pc
          hold_d = hold_q - CNT_WIDTH'(1);
          if (hold_q == CNT_WIDTH'(1)) begin
            pc_d = pc_q + PROG_ADDR_WIDTH'(1);
          end
        end else begin
          case (instr_op)
            OP_EMIT: begin
              ctrl_d  = instr_ctrl;
              valid_d = 1'b1;
              hold_d  = '0;
              pc_d    = pc_q + PROG_ADDR_WIDTH'(1);
            end
            OP_HOLD: begin
              ctrl_d  = instr_ctrl;
              valid_d = 1'b1;
              hold_d  = instr_cnt;
              if (instr_cnt == '0) begin
                pc_d = pc_q + PROG_ADDR_WIDTH'(1);
              end
            end
            OP_END: begin
              state_d = S_DONE;
              ctrl_d  = '0;
              valid_d = 1'b0;
            end
            default: begin
              state_d = S_DONE;
              ctrl_d  = '0;
              valid_d = 1'b0;
              error_d = 1'b1;
            end
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_FETCH) || (state_d == S_RUN);
    sel_d  = !busy_d;
    en_d   = busy_d;
  end

  assign prog.prog_addr = pc_q;
  assign prog.prog_en   = en_q;
  assign CTRL_Signal    = ctrl_q;
  assign ctrl_valid     = valid_q;
  assign bram_ZYNQ_sel  = sel_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign run_cycles     = runc_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer with a behavioural
// one-cycle-latency program memory.
module tb_ctrl_sequencer;

  logic        CLK_100;
  logic        RST;
  logic        start;
  logic [9:0]  start_addr;
  logic        stop;
  logic [59:0] CTRL_Signal;
  logic        ctrl_valid;
  logic        bram_ZYNQ_sel;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] run_cycles;

  int checks   = 0;
  int failures = 0;

  logic [71:0] mem [0:1023];

  ctrl_sequencer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(72)) bus ();

  ctrl_sequencer dut (
    .CLK_100      (CLK_100),
    .RST          (RST),
    .start        (start),
    .start_addr   (start_addr),
    .stop         (stop),
    .prog         (bus),
    .CTRL_Signal  (CTRL_Signal),
    .ctrl_valid   (ctrl_valid),
    .bram_ZYNQ_sel(bram_ZYNQ_sel),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .run_cycles   (run_cycles)
  );

  initial CLK_100 = 1'b0;
  always #5 CLK_100 = ~CLK_100;

  always @(posedge CLK_100) begin
    if (bus.prog_en) bus.prog_dout <= mem[bus.prog_addr];
  end

  localparam logic [59:0] CA = 60'h800_0000_0000_0A1;
  localparam logic [59:0] CB = 60'h123_4567_89AB_CDE;
  localparam logic [59:0] CC = 60'hC0C_0C0C_0C0C_0C0;
  localparam logic [59:0] CD = 60'h400_0000_0000_0DD;
  localparam logic [59:0] CE = 60'hEEE_0000_0000_001;
  localparam logic [59:0] CF = 60'hF0F_0000_0000_F0F;

  typedef struct {
    logic        start;
    logic [9:0]  saddr;
    logic        stop;
    logic [9:0]  addr;
    logic        en;
    logic        valid;
    logic [59:0] ctrl;
    logic        done;
    logic        busy;
    logic [31:0] runc;
  } vec_t;

  vec_t vt [15];

  function automatic logic [71:0] mk(input logic [1:0] op, input logic [9:0] cnt,
                                     input logic [59:0] c);
    return {op, cnt, c};
  endfunction

  function automatic vec_t row(input logic st, input logic [9:0] sa, input logic sp,
                               input logic [9:0] a, input logic en, input logic v,
                               input logic [59:0] c, input logic d, input logic b,
                               input logic [31:0] rc);
    vec_t r;
    r.start = st; r.saddr = sa; r.stop = sp; r.addr = a; r.en = en;
    r.valid = v; r.ctrl = c; r.done = d; r.busy = b; r.runc = rc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic drive(input logic st, input logic [9:0] sa, input logic sp);
    start = st; start_addr = sa; stop = sp;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = mk(2'b10, 10'd0, 60'd0);
    mem[5]    = mk(2'b00, 10'd0, CA);
    mem[6]    = mk(2'b00, 10'd0, CB);
    mem[7]    = mk(2'b10, 10'd0, 60'd0);
    mem[20]   = mk(2'b01, 10'd3, CC);
    mem[21]   = mk(2'b00, 10'd0, CD);
    mem[22]   = mk(2'b10, 10'd0, 60'd0);
    mem[40]   = mk(2'b00, 10'd0, CA);
    mem[41]   = mk(2'b11, 10'h3FF, CB);
    mem[60]   = mk(2'b01, 10'd10, CF);
    mem[61]   = mk(2'b10, 10'd0, 60'd0);
    mem[1023] = mk(2'b00, 10'd0, CE);
    mem[0]    = mk(2'b10, 10'd0, 60'd0);

    // EMIT A, EMIT B, END at 5; then HOLD 3 C, EMIT D, END at 20
    vt[0]  = row(1, 5,  0,  5, 1, 0, 60'd0, 0, 1, 0);
    vt[1]  = row(0, 0,  0,  6, 1, 0, 60'd0, 0, 1, 0);
    vt[2]  = row(0, 0,  0,  7, 1, 1, CA,    0, 1, 0);
    vt[3]  = row(0, 0,  0,  8, 1, 1, CB,    0, 1, 1);
    vt[4]  = row(0, 0,  0,  8, 0, 0, 60'd0, 1, 0, 2);
    vt[5]  = row(0, 0,  0,  8, 0, 0, 60'd0, 0, 0, 2);
    vt[6]  = row(1, 20, 0, 20, 1, 0, 60'd0, 0, 1, 0);
    vt[7]  = row(0, 0,  0, 21, 1, 0, 60'd0, 0, 1, 0);
    vt[8]  = row(0, 0,  0, 21, 1, 1, CC,    0, 1, 0);
    vt[9]  = row(0, 0,  0, 21, 1, 1, CC,    0, 1, 1);
    vt[10] = row(0, 0,  0, 21, 1, 1, CC,    0, 1, 2);
    vt[11] = row(0, 0,  0, 22, 1, 1, CC,    0, 1, 3);
    vt[12] = row(0, 0,  0, 23, 1, 1, CD,    0, 1, 4);
    vt[13] = row(0, 0,  0, 23, 0, 0, 60'd0, 1, 0, 5);
    vt[14] = row(0, 0,  0, 23, 0, 0, 60'd0, 0, 0, 5);

    RST = 1'b1;
    drive(0, 0, 0);
    tick();
    tick();
    chk("rst_addr",  64'(bus.prog_addr), 64'd0);
    chk("rst_en",    64'(bus.prog_en),   64'd0);
    chk("rst_valid", 64'(ctrl_valid),    64'd0);
    chk("rst_ctrl",  64'(CTRL_Signal),   64'd0);
    chk("rst_sel",   64'(bram_ZYNQ_sel), 64'd1);
    chk("rst_busy",  64'(busy),          64'd0);
    chk("rst_done",  64'(done),          64'd0);
    chk("rst_error", 64'(error),         64'd0);
    chk("rst_runc",  64'(run_cycles),    64'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].start, vt[i].saddr, vt[i].stop);
      tick();
      chk($sformatf("v%0d_addr", i),  64'(bus.prog_addr), 64'(vt[i].addr));
      chk($sformatf("v%0d_en", i),    64'(bus.prog_en),   64'(vt[i].en));
      chk($sformatf("v%0d_valid", i), 64'(ctrl_valid),    64'(vt[i].valid));
      chk($sformatf("v%0d_ctrl", i),  64'(CTRL_Signal),   64'(vt[i].ctrl));
      chk($sformatf("v%0d_done", i),  64'(done),          64'(vt[i].done));
      chk($sformatf("v%0d_busy", i),  64'(busy),          64'(vt[i].busy));
      chk($sformatf("v%0d_sel", i),   64'(bram_ZYNQ_sel), 64'(!vt[i].busy));
      chk($sformatf("v%0d_runc", i),  64'(run_cycles),    64'(vt[i].runc));
      chk($sformatf("v%0d_err", i),   64'(error),         64'd0);
    end
    drive(0, 0, 0);

    // Reserved opcode: EMIT A then opcode 11
    drive(1, 40, 0); tick();
    drive(0, 0, 0);  tick(); tick();
    chk("err_a_ctrl", 64'(CTRL_Signal), 64'(CA));
    tick();
    chk("err_done",  64'(done),       64'd1);
    chk("err_set",   64'(error),      64'd1);
    chk("err_valid", 64'(ctrl_valid), 64'd0);
    chk("err_runc",  64'(run_cycles), 64'd1);
    tick(); tick(); tick();
    chk("err_sticky", 64'(error), 64'd1);
    chk("err_idle_done", 64'(done), 64'd0);

    // Restart clears error; start while busy must be ignored
    drive(1, 5, 0); tick();
    chk("err_clear", 64'(error), 64'd0);
    chk("rs_addr0",  64'(bus.prog_addr), 64'd5);
    drive(1, 40, 0); tick();
    chk("busy_start_addr1", 64'(bus.prog_addr), 64'd6);
    tick();
    chk("busy_start_addr2", 64'(bus.prog_addr), 64'd7);
    chk("busy_start_ctrl",  64'(CTRL_Signal),   64'(CA));
    drive(0, 0, 0); tick();
    chk("busy_start_ctrlb", 64'(CTRL_Signal), 64'(CB));
    tick();
    chk("busy_start_done",  64'(done), 64'd1);
    tick();

    // Address wrap from 1023 to 0
    drive(1, 10'd1023, 0); tick();
    chk("wrap_addr0", 64'(bus.prog_addr), 64'd1023);
    drive(0, 0, 0); tick();
    chk("wrap_addr1", 64'(bus.prog_addr), 64'd0);
    tick();
    chk("wrap_ctrl",  64'(CTRL_Signal), 64'(CE));
    chk("wrap_addr2", 64'(bus.prog_addr), 64'd1);
    tick();
    chk("wrap_done",  64'(done),  64'd1);
    chk("wrap_error", 64'(error), 64'd0);
    tick();

    // stop in third cycle of HOLD cnt=10
    drive(1, 60, 0); tick();
    drive(0, 0, 0);  tick(); tick(); tick(); tick();
    chk("stop_pre_ctrl", 64'(CTRL_Signal), 64'(CF));
    drive(0, 0, 1); tick();
    drive(0, 0, 0);
    chk("stop_busy",  64'(busy),          64'd0);
    chk("stop_valid", 64'(ctrl_valid),    64'd0);
    chk("stop_ctrl",  64'(CTRL_Signal),   64'd0);
    chk("stop_done",  64'(done),          64'd0);
    chk("stop_sel",   64'(bram_ZYNQ_sel), 64'd1);
    chk("stop_en",    64'(bus.prog_en),   64'd0);
    chk("stop_runc",  64'(run_cycles),    64'd3);
    tick();
    chk("stop_no_done", 64'(done), 64'd0);
    chk("stop_idle",    64'(busy), 64'd0);

    // start together with stop in IDLE
    drive(1, 5, 1); tick();
    drive(0, 0, 0);
    chk("ss_busy", 64'(busy),        64'd0);
    chk("ss_en",   64'(bus.prog_en), 64'd0);
    tick();
    chk("ss_busy2", 64'(busy), 64'd0);

    // RST during HOLD
    drive(1, 60, 0); tick();
    drive(0, 0, 0);  tick(); tick(); tick();
    chk("rh_pre_valid", 64'(ctrl_valid), 64'd1);
    RST = 1'b1; tick();
    RST = 1'b0;
    chk("rh_addr",  64'(bus.prog_addr), 64'd0);
    chk("rh_en",    64'(bus.prog_en),   64'd0);
    chk("rh_valid", 64'(ctrl_valid),    64'd0);
    chk("rh_ctrl",  64'(CTRL_Signal),   64'd0);
    chk("rh_done",  64'(done),          64'd0);
    chk("rh_runc",  64'(run_cycles),    64'd0);
    chk("rh_sel",   64'(bram_ZYNQ_sel), 64'd1);
    chk("rh_busy",  64'(busy),          64'd0);
    tick();
    chk("rh_stay_valid", 64'(ctrl_valid), 64'd0);

    // RST clears a sticky error and beats a simultaneous start
    drive(1, 40, 0); tick();
    drive(0, 0, 0);  tick(); tick(); tick(); tick();
    chk("re_err_set", 64'(error), 64'd1);
    RST = 1'b1; drive(1, 5, 0); tick();
    RST = 1'b0; drive(0, 0, 0);
    chk("re_err_clr", 64'(error), 64'd0);
    chk("re_busy",    64'(busy),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 60: width of control word driven to the LU datapath.
REQ-002 SHALL have parameter PROG_ADDR_WIDTH, default 10: program memory address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 10: hold-count field width; instruction width IW = CTRL_WIDTH+2+CNT_WIDTH (72 at defaults).
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports CLK_100 and RST.
REQ-005 CLK_100  input  1  clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 start  input  1  begin program run at start_addr; sampled only in IDLE.
REQ-008 start_addr  input  PROG_ADDR_WIDTH  first instruction address.
REQ-009 stop  input  1  abort run.
REQ-010 prog_addr  output  PROG_ADDR_WIDTH  program memory read address (= pc).
REQ-011 prog_en  output  1  program memory read enable.
REQ-012 prog_dout  input  IW  program memory read data, 1-cycle latency after prog_addr/prog_en.
REQ-013 CTRL_Signal  output  CTRL_WIDTH  registered control word to datapath.
REQ-014 ctrl_valid  output  1  CTRL_Signal carries a program word this cycle.
REQ-015 bram_ZYNQ_sel  output  1  high = ZYNQ owns data BRAM port A; high in IDLE and DONE, low in FETCH and RUN.
REQ-016 busy  output  1  high in FETCH and RUN.
REQ-017 done  output  1  one-cycle pulse on normal completion.
REQ-018 error  output  1  sticky: reserved opcode executed; cleared on accepted start.
REQ-019 run_cycles  output  32  count of cycles with ctrl_valid=1 in current/last run; cleared on accepted start; saturates at 0xFFFFFFFF.

Function
REQ-020 Instruction fields SHALL be op = [IW-1:IW-2], cnt = [IW-3:CTRL_WIDTH], ctrl = [CTRL_WIDTH-1:0].
REQ-021 Opcodes SHALL be 00 EMIT (ctrl for 1 cycle), 01 HOLD (ctrl for cnt+1 cycles), 10 END, 11 reserved (END plus error set).
REQ-022 States SHALL be IDLE, FETCH, RUN, DONE; prog_en = 1 exactly in FETCH and RUN.
REQ-023 IDLE: start=1 and stop=0 -> FETCH; pc <= start_addr; error <= 0; run_cycles <= 0; start in any other state ignored.
REQ-024 FETCH (one cycle): prog_addr = start_addr; at edge pc <= pc+1, state -> RUN.
REQ-025 RUN with hold_cnt=0: decode prog_dout; EMIT/HOLD -> CTRL_Signal <= ctrl, ctrl_valid <= 1, hold_cnt <= (HOLD ? cnt : 0), pc <= pc+1 only when loaded hold_cnt = 0.
REQ-026 RUN with hold_cnt>0: CTRL_Signal and ctrl_valid unchanged, prog_dout ignored, hold_cnt decrements; when it reaches 0, pc <= pc+1 in that same edge, so the next instruction is decoded the following cycle.
REQ-027 First CTRL_Signal word SHALL appear 2 cycles after the start-accept edge; back-to-back EMITs SHALL produce one new word per cycle with no bubbles.
REQ-028 END/reserved decoded in RUN: -> DONE; CTRL_Signal <= 0; ctrl_valid <= 0; pc unchanged.
REQ-029 DONE: done=1 for exactly that cycle; -> IDLE next edge.
REQ-030 stop=1 in FETCH or RUN: -> IDLE next edge, CTRL_Signal <= 0, ctrl_valid <= 0, hold_cnt <= 0, no done pulse; stop overrides any simultaneous decode. stop=1 with start=1 in IDLE: remain IDLE.
REQ-031 pc SHALL wrap modulo 2^PROG_ADDR_WIDTH without error.
REQ-032 CTRL_Signal SHALL be all-zero whenever ctrl_valid=0.
REQ-033 run_cycles SHALL increment on every cycle with ctrl_valid=1.

Reset
REQ-034 RST=1 SHALL force IDLE, pc=0, hold_cnt=0, CTRL_Signal=0, ctrl_valid=0, done=0, error=0, run_cycles=0, bram_ZYNQ_sel=1, busy=0, from the next edge, regardless of state, including mid-HOLD.
REQ-035 RST SHALL take priority over start and stop.

Verification
REQ-036 Program @5: EMIT A, EMIT B, END; start, start_addr=5 -> prog_addr 5,6,7; CTRL_Signal A then B on consecutive cycles 2 and 3 after accept; done pulses once; run_cycles=2; bram_ZYNQ_sel low only during FETCH/RUN.
REQ-037 HOLD cnt=3 ctrl=C, then EMIT D, END -> C for exactly 4 cycles, D for 1 cycle; run_cycles=5.
REQ-038 Program EMIT A, opcode 11 -> A for 1 cycle, then DONE; error=1 sticky until next start, cleared on accept.
REQ-039 Start at address 2^PROG_ADDR_WIDTH-1 with EMIT, program continues at 0 with END -> prog_addr wraps 1023 -> 0; normal done.
REQ-040 stop asserted during HOLD cnt=10 third cycle -> IDLE next edge, CTRL_Signal=0, no done; RST during HOLD -> all outputs per REQ-034.
REQ-041 start while busy ignored; start and stop together in IDLE -> stays IDLE, busy=0.
